// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM states, the
// load header byte and the bytes-per-word helper.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADR,
    CNT,
    DATA,
    WRITE
  } state_t;

  localparam logic [7:0] HDR_BYTE = 8'hA5;

  function automatic int bytes_per_word(input int word_width);
    return (word_width + 7) / 8;
  endfunction

endpackage

// File: rtl/imem_word_assembler.sv
// Collects little-endian bytes into one instruction word; byte k lands in
// bits 8k+7:8k and bits beyond the word width are dropped.
module imem_word_assembler
  import imem_loader_pkg::*;
#(
  parameter int W = 46
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clear,
  input  logic         byte_valid,
  input  logic [7:0]   byte_data,
  output logic [W-1:0] word_next,
  output logic         word_done
);

  localparam int B = bytes_per_word(W);
  localparam int IDX_W = (B > 1) ? $clog2(B) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(B - 1);

  logic [IDX_W-1:0] byte_idx;
  logic [W-1:0]     word_q;

  // word_next already contains the byte being accepted, so the loader can
  // capture a complete word on the same edge that takes the final byte.
  always_comb begin
    word_next = word_q;
    for (int b = 0; b < W; b++) begin
      if (IDX_W'(b / 8) == byte_idx) word_next[b] = byte_data[3'(b % 8)];
    end
  end

  assign word_done = byte_valid && (byte_idx == LAST_IDX);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_idx <= '0;
      word_q   <= '0;
    end else if (clear) begin
      byte_idx <= '0;
    end else if (byte_valid) begin
      word_q   <= word_next;
      byte_idx <= word_done ? '0 : byte_idx + 1'b1;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Receives a header/address/count/data byte stream from the host link and
// writes packed instruction words into the instruction buffer.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int i_adr_width   = 8,
  parameter int i_width       = 23,
  parameter int i_buffer_size = 2
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [7:0]                        rx_data,
  input  logic                              rx_valid,
  output logic                              rx_ready,
  input  logic                              abort,
  output logic                              imem_write,
  output logic [i_adr_width-1:0]            imem_write_adr,
  output logic [i_buffer_size*i_width-1:0]  imem_in,
  output logic                              busy,
  output logic                              done,
  output logic                              hdr_error
);

  localparam int W = i_buffer_size * i_width;

  state_t                 state, state_next;
  logic [i_adr_width-1:0] adr_q;
  logic [8:0]             cnt_q;
  logic                   accept;
  logic                   data_byte;
  logic                   word_done;
  logic [W-1:0]           word_next;

  assign rx_ready   = (state != WRITE) && !abort;
  assign accept     = rx_valid && rx_ready;
  assign data_byte  = accept && (state == DATA);
  assign busy       = (state != IDLE);
  assign imem_write = (state == WRITE) && !abort;

  imem_word_assembler #(.W(W)) u_assembler (
    .clk        (clk),
    .reset      (reset),
    .clear      (abort),
    .byte_valid (data_byte),
    .byte_data  (rx_data),
    .word_next  (word_next),
    .word_done  (word_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (abort) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept && rx_data == HDR_BYTE) state_next = ADR;
        ADR:     if (accept) state_next = CNT;
        CNT:     if (accept) state_next = DATA;
        DATA:    if (word_done) state_next = WRITE;
        WRITE:   state_next = (cnt_q == 9'd1) ? IDLE : DATA;
        default: state_next = IDLE;
      endcase
    end
  end

  // Output address/word are captured separately from adr_q so they hold
  // steady between writes while adr_q advances.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      adr_q          <= '0;
      cnt_q          <= '0;
      imem_write_adr <= '0;
      imem_in        <= '0;
      done           <= 1'b0;
      hdr_error      <= 1'b0;
    end else begin
      done <= (state == WRITE) && !abort && (cnt_q == 9'd1);
      if (accept) begin
        case (state)
          IDLE:    hdr_error <= (rx_data != HDR_BYTE);
          ADR:     adr_q <= i_adr_width'(rx_data);
          CNT:     cnt_q <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          default: ;
        endcase
      end
      if (word_done) begin
        imem_write_adr <= adr_q;
        imem_in        <= word_next;
      end
      if (state == WRITE && !abort) begin
        adr_q <= adr_q + 1'b1;
        cnt_q <= cnt_q - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: a byte-stream reference model predicts
// every write and done pulse; a monitor compares them as the DUT emits them.
module tb_imem_loader;

  localparam int AW = 8;
  localparam int IW = 23;
  localparam int BS = 2;
  localparam int W  = IW * BS;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          abort;
  logic          imem_write;
  logic [AW-1:0] imem_write_adr;
  logic [W-1:0]  imem_in;
  logic          busy;
  logic          done;
  logic          hdr_error;

  always #5 clk = ~clk;

  imem_loader #(.i_adr_width(AW), .i_width(IW), .i_buffer_size(BS)) dut (
    .clk            (clk),
    .reset          (reset),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_ready       (rx_ready),
    .abort          (abort),
    .imem_write     (imem_write),
    .imem_write_adr (imem_write_adr),
    .imem_in        (imem_in),
    .busy           (busy),
    .done           (done),
    .hdr_error      (hdr_error)
  );

  typedef struct {
    bit           is_done;
    logic [7:0]   adr;
    logic [W-1:0] data;
  } ev_t;

  ev_t        exp_q[$];
  logic [7:0] stim_q[$];
  bit         last_q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  bit         model_hdr_err = 1'b0;
  int         stalls;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic reportFail(input string msg);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s", msg);
  endtask

  // Reference model: walks the first `upto` bytes of stim_q as a host would
  // describe them (header, address, count, then 6-byte little-endian words).
  task automatic modelStream(input int upto);
    int          phase = 0;
    logic [7:0]  adr = '0;
    int          remaining = 0;
    logic [47:0] acc = '0;
    int          k = 0;
    ev_t         e;
    last_q.delete();
    for (int i = 0; i < upto; i++) begin
      logic [7:0] b;
      bit last;
      b = stim_q[i];
      last = 1'b0;
      case (phase)
        0: if (b == 8'hA5) begin phase = 1; model_hdr_err = 1'b0; end
           else model_hdr_err = 1'b1;
        1: begin adr = b; phase = 2; end
        2: begin remaining = (b == 0) ? 256 : int'(b); phase = 3; acc = '0; k = 0; end
        default: begin
          acc = acc | (48'(b) << (8 * k));
          k++;
          if (k == 6) begin
            e.is_done = 1'b0; e.adr = adr; e.data = acc[W-1:0];
            exp_q.push_back(e);
            last = 1'b1;
            adr = adr + 8'd1;
            remaining--;
            k = 0;
            acc = '0;
            if (remaining == 0) begin
              e.is_done = 1'b1;
              exp_q.push_back(e);
              phase = 0;
            end
          end
        end
      endcase
      last_q.push_back(last);
    end
  endtask

  task automatic addLoad(input logic [7:0] adr, input logic [7:0] cnt, input int nbytes);
    stim_q.push_back(8'hA5);
    stim_q.push_back(adr);
    stim_q.push_back(cnt);
    for (int i = 0; i < nbytes; i++) stim_q.push_back(8'($urandom_range(255, 0)));
  endtask

  // Drives stim_q with a valid/ready handshake; entered and left #1 after a
  // rising edge.
  task automatic applyStimulus(input bit continuous, input int max_gap);
    stalls = 0;
    foreach (stim_q[i]) begin
      bit acc;
      int w;
      rx_data  = stim_q[i];
      rx_valid = 1'b1;
      w = 0;
      do begin
        acc = rx_ready;
        if (!acc) stalls++;
        @(posedge clk);
        #1;
        w++;
      end while (!acc && w < 100);
      if (!acc) reportFail($sformatf("accept_timeout: byte %0d, rx_ready=0, expected 1", i));
      if (last_q[i]) checkOutput("write_strobe_t_plus_1", 64'(imem_write), 64'd1);
      if (!continuous) begin
        rx_valid = 1'b0;
        repeat ($urandom_range(max_gap, 0)) begin @(posedge clk); #1; end
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic finishScenario();
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    checkOutput("busy_idle", 64'(busy), 64'd0);
    checkOutput("hdr_error", 64'(hdr_error), 64'(model_hdr_err));
    exp_q.delete();
    stim_q.delete();
  endtask

  // Monitor: every strobe from the DUT must match the next predicted event.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (imem_write === 1'b1) begin
        if (exp_q.size() == 0 || exp_q[0].is_done) begin
          reportFail($sformatf("unexpected_write: adr 0x%0h data 0x%0h, none expected", imem_write_adr, imem_in));
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          checkOutput("write_adr", 64'(imem_write_adr), 64'(e.adr));
          checkOutput("write_data", 64'(imem_in), 64'(e.data));
          checkOutput("rx_ready_low_in_write", 64'(rx_ready), 64'd0);
          checkOutput("busy_in_write", 64'(busy), 64'd1);
        end
      end
      if (done === 1'b1) begin
        if (exp_q.size() == 0 || !exp_q[0].is_done) begin
          reportFail("unexpected_done: done=1, expected 0");
        end else begin
          ev_t e;
          e = exp_q.pop_front();
          checkOutput("done_busy_low", 64'(busy), 64'd0);
          checkOutput("done_adr_hold", 64'(imem_write_adr), 64'(e.adr));
          checkOutput("done_data_hold", 64'(imem_in), 64'(e.data));
        end
      end
    end
  end

  initial begin
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    abort    = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_imem_write", 64'(imem_write), 64'd0);
    checkOutput("rst_adr", 64'(imem_write_adr), 64'd0);
    checkOutput("rst_imem_in", 64'(imem_in), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_hdr_error", 64'(hdr_error), 64'd0);
    checkOutput("rst_rx_ready", 64'(rx_ready), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Two-word load of 01..0C at 0x10.
    stim_q = '{8'hA5, 8'h10, 8'h02};
    for (int i = 1; i <= 12; i++) stim_q.push_back(8'(i));
    modelStream(stim_q.size());
    applyStimulus(1'b0, 2);
    finishScenario();

    // Address wrap 0xFF -> 0x00.
    addLoad(8'hFF, 8'h02, 12);
    modelStream(stim_q.size());
    applyStimulus(1'b0, 1);
    finishScenario();

    // rx_valid held high: one stall per WRITE that has a byte waiting.
    addLoad(8'h50, 8'h02, 12);
    modelStream(stim_q.size());
    applyStimulus(1'b1, 0);
    checkOutput("stall_cycles_2word", 64'(stalls), 64'd1);
    finishScenario();

    // Abort after one full word and a partial second word.
    addLoad(8'h20, 8'h03, 9);
    modelStream(stim_q.size());
    applyStimulus(1'b0, 1);
    repeat (2) begin @(posedge clk); #1; end
    abort    = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'h77;
    #1;
    checkOutput("rx_ready_during_abort", 64'(rx_ready), 64'd0);
    @(posedge clk);
    #1;
    abort    = 1'b0;
    rx_valid = 1'b0;
    checkOutput("busy_after_abort", 64'(busy), 64'd0);
    finishScenario();

    // A bad header byte right after the abort lands in IDLE and flags an error.
    stim_q = '{8'h3C};
    modelStream(1);
    applyStimulus(1'b0, 0);
    @(posedge clk);
    #1;
    checkOutput("hdr_error_set", 64'(hdr_error), 64'(model_hdr_err));
    stim_q.delete();
    addLoad(8'h00, 8'h01, 6);
    modelStream(stim_q.size());
    applyStimulus(1'b0, 2);
    finishScenario();

    // Randomised loads.
    for (int r = 0; r < 4; r++) begin
      int cnt;
      cnt = $urandom_range(3, 1);
      addLoad(8'($urandom_range(255, 0)), 8'(cnt), 6 * cnt);
      modelStream(stim_q.size());
      applyStimulus(1'b0, 2);
      finishScenario();
    end

    // Count byte 0 means 256 words.
    addLoad(8'($urandom_range(255, 0)), 8'h00, 6 * 256);
    modelStream(stim_q.size());
    applyStimulus(1'b1, 0);
    checkOutput("stall_cycles_256word", 64'(stalls), 64'd255);
    finishScenario();

    // Reset in the middle of a 4-word load.
    addLoad(8'h30, 8'h04, 8);
    modelStream(stim_q.size());
    applyStimulus(1'b0, 1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_imem_write", 64'(imem_write), 64'd0);
    checkOutput("midrst_adr", 64'(imem_write_adr), 64'd0);
    checkOutput("midrst_imem_in", 64'(imem_in), 64'd0);
    checkOutput("midrst_busy", 64'(busy), 64'd0);
    checkOutput("midrst_done", 64'(done), 64'd0);
    checkOutput("midrst_hdr_error", 64'(hdr_error), 64'd0);
    model_hdr_err = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    checkOutput("rx_ready_after_release", 64'(rx_ready), 64'd1);
    repeat (20) begin @(posedge clk); #1; end
    finishScenario();
    addLoad(8'h60, 8'h01, 6);
    modelStream(stim_q.size());
    applyStimulus(1'b0, 1);
    finishScenario();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter i_adr_width, default 8, instruction-memory address width.
REQ-002 SHALL have parameter i_width, default 23, width of one instruction.
REQ-003 SHALL have parameter i_buffer_size, default 2, instructions per memory word; word width W = i_buffer_size*i_width (46).
REQ-004 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port rx_data, input, 8, byte from host link.
REQ-007 SHALL have port rx_valid, input, 1, rx_data valid.
REQ-008 SHALL have port rx_ready, output, 1, loader accepts a byte this cycle.
REQ-009 SHALL have port abort, input, 1, synchronous load cancel.
REQ-010 SHALL have port imem_write, output, 1, one-cycle write strobe to the instruction buffer.
REQ-011 SHALL have port imem_write_adr, output, i_adr_width, write address.
REQ-012 SHALL have port imem_in, output, W, packed instruction word.
REQ-013 SHALL have port busy, output, 1, load in progress; used to hold the PAT core in reset.
REQ-014 SHALL have port done, output, 1, one-cycle pulse at load completion.
REQ-015 SHALL have port hdr_error, output, 1, sticky bad-header flag.

Function
REQ-016 SHALL accept a byte only in a cycle where rx_valid and rx_ready are both 1.
REQ-017 SHALL use states IDLE, ADR, CNT, DATA, WRITE; rx_ready=1 in IDLE/ADR/CNT/DATA, 0 in WRITE and whenever abort=1.
REQ-018 In IDLE, an accepted byte 0xA5 SHALL move to ADR and clear hdr_error; any other byte SHALL be discarded and set hdr_error.
REQ-019 In ADR, the accepted byte SHALL load the address register (low i_adr_width bits), then move to CNT.
REQ-020 In CNT, the accepted byte SHALL load word count N, with 0 meaning 256, then move to DATA.
REQ-021 In DATA, bytes SHALL assemble little-endian: byte k fills bits 8k+7:8k; B = ceil(W/8) = 6 bytes per word; bits above W-1 are dropped.
REQ-022 Acceptance of byte B-1 at cycle t SHALL enter WRITE; imem_write=1 for exactly cycle t+1, with imem_write_adr and imem_in valid in that cycle.
REQ-023 After WRITE, address SHALL increment modulo 2^i_adr_width (0xFF wraps to 0x00) and remaining count SHALL decrement; next state is DATA if count>0, else IDLE.
REQ-024 On leaving WRITE with count exhausted, done SHALL pulse 1 for the cycle after the final imem_write, and busy SHALL drop in that same cycle.
REQ-025 busy SHALL be 1 in ADR, CNT, DATA, WRITE and 0 in IDLE.
REQ-026 imem_write_adr and imem_in SHALL hold their last values between writes.
REQ-027 abort=1 SHALL force IDLE next cycle from any state, discard a partial word, suppress any pending write, and produce no done; abort wins over a simultaneous byte.
REQ-028 A byte arriving in WRITE SHALL stall (rx_ready=0) and be accepted in the next DATA/IDLE cycle; no byte SHALL be lost.

Reset
REQ-029 reset=0 SHALL asynchronously force state IDLE, imem_write=0, imem_write_adr=0, imem_in=0, busy=0, done=0, hdr_error=0, byte index 0, count 0.
REQ-030 Reset asserted mid-load SHALL abandon the load with no further writes; rx_ready SHALL read 1 after reset release.

Structure
REQ-031 Package imem_loader_pkg SHALL hold the state enum, header constant 0xA5, and bytes-per-word computation.
REQ-032 Byte assembly (shift register plus byte index) SHALL be sub-module imem_word_assembler; FSM, address and count logic remain in imem_loader.

Verification
REQ-033 Bytes A5,10,02 + 12 data bytes 01..0C -> writes at 0x10 (imem_in=0x060504030201 masked to 46 bits = 0x060504030201) and 0x11 (0x0C0B0A090807 masked = 0x0C0B0A090807), then done pulse.
REQ-034 Header 3C then A5,00,01 + 6 bytes -> hdr_error=1 after 3C, cleared on A5, one write at 0x00.
REQ-035 A5,FF,02 + 12 bytes -> writes at 0xFF then 0x00 (wrap).
REQ-036 A5,20,03, 9 data bytes, abort pulse -> exactly one write at 0x20, no done, busy=0, state IDLE.
REQ-037 rx_valid held high continuously through a 2-word load -> rx_ready low only in each WRITE cycle; all 12 bytes captured.
REQ-038 reset=0 during DATA of a 4-word load -> all outputs at reset values immediately, no write after release.
